cache_ctrl_fsm: RTL and testbench

//  Control FSM for the 4-way set-associative LFU cache datapath (1024 sets, 64-bit lines of 4x16-bit words).

---
 rtl/cache_ctrl_fsm.sv | 243 ++++++++++++++++++++++++
 tb/tb_cache_ctrl_fsm.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_fsm.sv
// cache_ctrl_fsm: control FSM for a 4-way set-associative LFU cache datapath.
// Accepts one CPU access at a time. It drives the tag/data/LFU strobes and
// sequences RAM line fills on a read miss and word write-through on every write.
// It also keeps saturating hit and miss statistics.
// Ports:
//   clk, gen_reset            clock, synchronous active-high reset
//   run, RW, word_sel         CPU request, direction (1 = write), word index
//   hit                       datapath tag-compare result (valid in COMPARE)
//   ram_ack                   RAM completion
//   SelecMemCPU .. enable_contadores   datapath strobes
//   ram_req, ram_we           RAM request and direction (1 = word write)
//   done, error, busy         CPU handshake
//   hit_count, miss_count     saturating statistics
module cache_ctrl_fsm #(
  parameter int unsigned RAM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             gen_reset,
  input  logic             run,
  input  logic             RW,
  input  logic [1:0]       word_sel,
  input  logic             hit,
  input  logic             ram_ack,
  output logic             SelecMemCPU,
  output logic             ReadEnableTag,
  output logic             ReadEnableData,
  output logic             count_read,
  output logic [1:0]       write_enable_cpu,
  output logic             cpu_word_we,
  output logic             write_enable_ram,
  output logic             enable_contadores,
  output logic             ram_req,
  output logic             ram_we,
  output logic             done,
  output logic             error,
  output logic             busy,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int unsigned TO_W = $clog2(RAM_TIMEOUT + 1);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_LOOKUP   = 4'd1;
  localparam logic [3:0] S_COMPARE  = 4'd2;
  localparam logic [3:0] S_RD_HIT   = 4'd3;
  localparam logic [3:0] S_FILL_REQ = 4'd4;
  localparam logic [3:0] S_FILL     = 4'd5;
  localparam logic [3:0] S_WR_CACHE = 4'd6;
  localparam logic [3:0] S_WR_RAM   = 4'd7;
  localparam logic [3:0] S_DONE     = 4'd8;
  localparam logic [3:0] S_ERR      = 4'd9;

  logic [3:0]       state_q, state_d;
  logic             rw_q, rw_d;
  logic [1:0]       word_q, word_d;
  logic             refill_q, refill_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic             hit_inc, miss_inc;

  // Registered copies of the state-decoded strobes
  logic       sel_q, sel_d;
  logic       rd_q, rd_d;
  logic [1:0] wec_q, wec_d;
  logic       cww_q, cww_d;
  logic       wer_q, wer_d;
  logic       ec_q, ec_d;
  logic       req_q, req_d;
  logic       rwe_q, rwe_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       busy_q, busy_d;

  // Next-state, latched request and statistics logic
  always_comb begin
    state_d  = state_q;
    rw_d     = rw_q;
    word_d   = word_q;
    refill_d = refill_q;
    to_cnt_d = to_cnt_q;
    hit_inc  = 1'b0;
    miss_inc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          rw_d    = RW;
          word_d  = word_sel;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: state_d = S_COMPARE;
      S_COMPARE: begin
        if (hit) begin
          state_d = rw_q ? S_WR_CACHE : S_RD_HIT;
        end else if (rw_q) begin
          miss_inc = 1'b1;
          to_cnt_d = '0;
          state_d  = S_WR_RAM;
        end else if (refill_q) begin
          // A freshly filled line must hit; a second miss is fatal
          state_d = S_ERR;
        end else begin
          miss_inc = 1'b1;
          to_cnt_d = '0;
          state_d  = S_FILL_REQ;
        end
      end
      S_RD_HIT: begin
        hit_inc = ~refill_q;
        state_d = S_DONE;
      end
      S_FILL_REQ, S_WR_RAM: begin
        // Ack wins over timeout when both land in the same cycle
        if (ram_ack) begin
          state_d = (state_q == S_FILL_REQ) ? S_FILL : S_DONE;
        end else if (to_cnt_q == TO_W'(RAM_TIMEOUT)) begin
          state_d = S_ERR;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      S_FILL: begin
        refill_d = 1'b1;
        state_d  = S_LOOKUP;
      end
      S_WR_CACHE: begin
        hit_inc  = 1'b1;
        to_cnt_d = '0;
        state_d  = S_WR_RAM;
      end
      S_DONE, S_ERR: begin
        refill_d = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    hit_cnt_d  = (hit_inc && (hit_cnt_q != '1)) ? hit_cnt_q + CNT_W'(1) : hit_cnt_q;
    miss_cnt_d = (miss_inc && (miss_cnt_q != '1)) ? miss_cnt_q + CNT_W'(1) : miss_cnt_q;
  end

  // Moore strobes decoded from the next state so the registered outputs line up with the state
  always_comb begin
    sel_d  = 1'b0;
    rd_d   = 1'b0;
    wec_d  = 2'd0;
    cww_d  = 1'b0;
    wer_d  = 1'b0;
    ec_d   = 1'b0;
    req_d  = 1'b0;
    rwe_d  = 1'b0;
    done_d = 1'b0;
    err_d  = 1'b0;
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_LOOKUP:   rd_d = 1'b1;
      S_RD_HIT:   ec_d = 1'b1;
      S_FILL_REQ: req_d = 1'b1;
      S_FILL: begin
        wer_d = 1'b1;
        ec_d  = 1'b1;
      end
      S_WR_CACHE: begin
        sel_d = 1'b1;
        cww_d = 1'b1;
        wec_d = word_d;
        ec_d  = 1'b1;
      end
      S_WR_RAM: begin
        req_d = 1'b1;
        rwe_d = 1'b1;
      end
      S_DONE: done_d = 1'b1;
      S_ERR: begin
        done_d = 1'b1;
        err_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (gen_reset) begin
      state_q    <= S_IDLE;
      rw_q       <= 1'b0;
      word_q     <= 2'd0;
      refill_q   <= 1'b0;
      to_cnt_q   <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      sel_q      <= 1'b0;
      rd_q       <= 1'b0;
      wec_q      <= 2'd0;
      cww_q      <= 1'b0;
      wer_q      <= 1'b0;
      ec_q       <= 1'b0;
      req_q      <= 1'b0;
      rwe_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rw_q       <= rw_d;
      word_q     <= word_d;
      refill_q   <= refill_d;
      to_cnt_q   <= to_cnt_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      sel_q      <= sel_d;
      rd_q       <= rd_d;
      wec_q      <= wec_d;
      cww_q      <= cww_d;
      wer_q      <= wer_d;
      ec_q       <= ec_d;
      req_q      <= req_d;
      rwe_q      <= rwe_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign SelecMemCPU       = sel_q;
  assign ReadEnableTag     = rd_q;
  assign ReadEnableData    = rd_q;
  assign count_read        = rd_q;
  assign write_enable_cpu  = wec_q;
  assign cpu_word_we       = cww_q;
  assign write_enable_ram  = wer_q;
  assign enable_contadores = ec_q;
  assign ram_req           = req_q;
  assign ram_we            = rwe_q;
  assign done              = done_q;
  assign error             = err_q;
  assign busy              = busy_q;
  assign hit_count         = hit_cnt_q;
  assign miss_count        = miss_cnt_q;

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// tb_cache_ctrl_fsm: self-checking bench for cache_ctrl_fsm.
// Transactions are driven with a responsive RAM and hit source. Each outcome is
// compared with a reference computed from the access rules: the path taken, the
// ack delay, the timeout and saturating statistics.
// Cycle numbering: cycle 0 is the IDLE cycle in which run is presented.
module tb_cache_ctrl_fsm;

  localparam int unsigned T     = 4;
  localparam int unsigned CW    = 2;
  localparam int          MAXC  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          gen_reset, run, RW, hit, ram_ack;
  logic [1:0]    word_sel;
  logic          SelecMemCPU, ReadEnableTag, ReadEnableData, count_read;
  logic [1:0]    write_enable_cpu;
  logic          cpu_word_we, write_enable_ram, enable_contadores;
  logic          ram_req, ram_we, done, error, busy;
  logic [CW-1:0] hit_count, miss_count;

  int checks   = 0;
  int failures = 0;
  int exp_hit  = 0;
  int exp_miss = 0;

  typedef struct {
    int done_cyc;
    int err;
    int req_cyc;
    int lookups;
    int ec;
    int wer;
    int wer_bad;
    int cww;
    int cww_bad;
    int ramwe_bad;
    int busy_bad;
    int idle_bad;
    int hit_inc;
    int miss_inc;
  } txn_t;

  cache_ctrl_fsm #(.RAM_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk(clk), .gen_reset(gen_reset), .run(run), .RW(RW), .word_sel(word_sel),
    .hit(hit), .ram_ack(ram_ack), .SelecMemCPU(SelecMemCPU),
    .ReadEnableTag(ReadEnableTag), .ReadEnableData(ReadEnableData),
    .count_read(count_read), .write_enable_cpu(write_enable_cpu),
    .cpu_word_we(cpu_word_we), .write_enable_ram(write_enable_ram),
    .enable_contadores(enable_contadores), .ram_req(ram_req), .ram_we(ram_we),
    .done(done), .error(error), .busy(busy), .hit_count(hit_count),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: outcome of one access from the access rules alone.
  // Read hit: 4 cycles. Read miss with ack in request cycle k: fill, then a
  // repeat lookup (7+k cycles). Write hit: word write and then write-through
  // (4+k). Write miss: write-through only (3+k). No ack by request cycle
  // T+1 means a timeout.
  function automatic txn_t model(bit rw, bit h1, bit h2, int k);
    txn_t e;
    bit   acked;
    int   rq;
    e = '{default: 0};
    acked = (k >= 1) && (k <= T + 1);
    rq = acked ? k : T + 1;
    e.lookups = 1;
    if (!rw && h1) begin
      e.done_cyc = 4; e.ec = 1; e.hit_inc = 1;
    end else if (!rw) begin
      e.miss_inc = 1; e.req_cyc = rq;
      if (!acked) begin
        e.done_cyc = 3 + rq; e.err = 1;
      end else begin
        e.wer = 1; e.lookups = 2;
        if (h2) begin e.done_cyc = 7 + k; e.ec = 2; end
        else begin e.done_cyc = 6 + k; e.ec = 1; e.err = 1; end
      end
    end else if (h1) begin
      e.hit_inc = 1; e.cww = 1; e.ec = 1; e.req_cyc = rq;
      e.done_cyc = 4 + rq; e.err = acked ? 0 : 1;
    end else begin
      e.miss_inc = 1; e.req_cyc = rq;
      e.done_cyc = 3 + rq; e.err = acked ? 0 : 1;
    end
    return e;
  endfunction

  task automatic bump(input txn_t e);
    if (e.hit_inc != 0 && exp_hit < MAXC) exp_hit++;
    if (e.miss_inc != 0 && exp_miss < MAXC) exp_miss++;
  endtask

  task automatic do_reset();
    gen_reset = 1'b1; run = 1'b0; RW = 1'b0; word_sel = 2'd0; hit = 1'b0; ram_ack = 1'b0;
    step();
    gen_reset = 1'b0;
    exp_hit = 0; exp_miss = 0;
  endtask

  // Drives one access and records what the DUT did; it makes no comparisons.
  task automatic run_txn(input bit rw, input bit [1:0] w, input bit h1, input bit h2,
                         input int k, input bit noise, output txn_t o);
    int lk;
    int rq;
    lk = 0; rq = 0;
    o = '{default: 0};
    o.done_cyc = -1;
    run = 1'b1; RW = rw; word_sel = w; hit = h1; ram_ack = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      step();
      run = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (ReadEnableTag) begin
        o.lookups++; lk++;
        hit = (lk == 1) ? h1 : h2;
      end
      if (enable_contadores) o.ec++;
      if (write_enable_ram) begin o.wer++; if (SelecMemCPU) o.wer_bad++; end
      if (cpu_word_we) begin
        o.cww++;
        if (!SelecMemCPU || write_enable_cpu !== w) o.cww_bad++;
      end
      if (ram_req) begin
        rq++; o.req_cyc++;
        if (ram_we !== rw) o.ramwe_bad++;
        ram_ack = (k > 0) && (rq == k);
      end else begin
        ram_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (!busy) o.busy_bad++;
      if (done) begin
        o.done_cyc = c; o.err = int'(error);
        run = 1'b0; ram_ack = 1'b0;
        break;
      end
    end
    step();
    if (busy || done || error || ram_req || ReadEnableTag || enable_contadores ||
        cpu_word_we || write_enable_ram) o.idle_bad = 1;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    checks++;
    if ({done, error, busy, ram_req, ram_we, SelecMemCPU, ReadEnableTag, ReadEnableData,
         count_read, cpu_word_we, write_enable_ram, enable_contadores, write_enable_cpu} !== '0) begin
      failures++; $display("FAIL reset_outputs: outputs not all zero after reset");
    end
    checks++;
    if (hit_count !== 0 || miss_count !== 0) begin
      failures++; $display("FAIL reset_counters: hit=%0d miss=%0d expected 0/0", hit_count, miss_count);
    end
  endtask

  task automatic test_read_hit();
    txn_t o, e;
    do_reset();
    e = model(1'b0, 1'b1, 1'b1, 0); bump(e);
    run_txn(1'b0, 2'd2, 1'b1, 1'b1, 0, 1'b0, o);
    checks++;
    if (o.done_cyc !== e.done_cyc || o.err !== 0) begin
      failures++; $display("FAIL read_hit_done: cyc=%0d err=%0d expected cyc=%0d err=0", o.done_cyc, o.err, e.done_cyc);
    end
    checks++;
    if (o.lookups !== 1 || o.ec !== 1 || o.req_cyc !== 0) begin
      failures++; $display("FAIL read_hit_strobes: lookups=%0d ec=%0d req=%0d expected 1/1/0", o.lookups, o.ec, o.req_cyc);
    end
    checks++;
    if (int'(hit_count) !== exp_hit || int'(miss_count) !== exp_miss || o.idle_bad !== 0) begin
      failures++; $display("FAIL read_hit_counts: hit=%0d miss=%0d idle_bad=%0d expected %0d/%0d/0", hit_count, miss_count, o.idle_bad, exp_hit, exp_miss);
    end
  endtask

  task automatic test_read_miss();
    txn_t o, e;
    do_reset();
    e = model(1'b0, 1'b0, 1'b1, 3); bump(e);
    run_txn(1'b0, 2'd1, 1'b0, 1'b1, 3, 1'b0, o);
    checks++;
    if (o.wer !== 1 || o.wer_bad !== 0 || o.lookups !== 2 || o.ramwe_bad !== 0) begin
      failures++; $display("FAIL read_miss_fill: wer=%0d wer_bad=%0d lookups=%0d ramwe_bad=%0d expected 1/0/2/0", o.wer, o.wer_bad, o.lookups, o.ramwe_bad);
    end
    checks++;
    if (o.done_cyc !== e.done_cyc || o.err !== 0 || o.req_cyc !== 3) begin
      failures++; $display("FAIL read_miss_done: cyc=%0d err=%0d req=%0d expected cyc=%0d err=0 req=3", o.done_cyc, o.err, o.req_cyc, e.done_cyc);
    end
    checks++;
    if (int'(miss_count) !== 1 || int'(hit_count) !== 0) begin
      failures++; $display("FAIL read_miss_counts: hit=%0d miss=%0d expected 0/1", hit_count, miss_count);
    end
  endtask

  task automatic test_write_hit();
    txn_t o, e;
    do_reset();
    e = model(1'b1, 1'b1, 1'b1, 1); bump(e);
    run_txn(1'b1, 2'd3, 1'b1, 1'b1, 1, 1'b0, o);
    checks++;
    if (o.cww !== 1 || o.cww_bad !== 0 || o.wer !== 0) begin
      failures++; $display("FAIL write_hit_word: cww=%0d cww_bad=%0d wer=%0d expected 1/0/0", o.cww, o.cww_bad, o.wer);
    end
    checks++;
    if (o.req_cyc !== 1 || o.ramwe_bad !== 0 || o.done_cyc !== e.done_cyc || o.err !== 0) begin
      failures++; $display("FAIL write_hit_ram: req=%0d ramwe_bad=%0d cyc=%0d err=%0d expected 1/0/%0d/0", o.req_cyc, o.ramwe_bad, o.done_cyc, o.err, e.done_cyc);
    end
    checks++;
    if (int'(hit_count) !== 1 || int'(miss_count) !== 0) begin
      failures++; $display("FAIL write_hit_counts: hit=%0d miss=%0d expected 1/0", hit_count, miss_count);
    end
  endtask

  task automatic test_write_miss();
    txn_t o, e;
    do_reset();
    e = model(1'b1, 1'b0, 1'b0, 2); bump(e);
    run_txn(1'b1, 2'd0, 1'b0, 1'b0, 2, 1'b0, o);
    checks++;
    if (o.cww !== 0 || o.wer !== 0 || o.req_cyc !== 2 || o.ramwe_bad !== 0) begin
      failures++; $display("FAIL write_miss_path: cww=%0d wer=%0d req=%0d ramwe_bad=%0d expected 0/0/2/0", o.cww, o.wer, o.req_cyc, o.ramwe_bad);
    end
    checks++;
    if (o.done_cyc !== e.done_cyc || int'(miss_count) !== 1 || int'(hit_count) !== 0) begin
      failures++; $display("FAIL write_miss_done: cyc=%0d miss=%0d hit=%0d expected %0d/1/0", o.done_cyc, miss_count, hit_count, e.done_cyc);
    end
  endtask

  task automatic test_timeout();
    txn_t o, e;
    do_reset();
    e = model(1'b0, 1'b0, 1'b1, 0); bump(e);
    run_txn(1'b0, 2'd0, 1'b0, 1'b1, 0, 1'b0, o);
    checks++;
    if (o.req_cyc !== T + 1 || o.err !== 1 || o.done_cyc !== e.done_cyc || o.wer !== 0) begin
      failures++; $display("FAIL timeout_err: req=%0d err=%0d cyc=%0d wer=%0d expected %0d/1/%0d/0", o.req_cyc, o.err, o.done_cyc, o.wer, T + 1, e.done_cyc);
    end
    // Ack on the very cycle the wait counter reaches the limit must win
    e = model(1'b1, 1'b1, 1'b1, T + 1); bump(e);
    run_txn(1'b1, 2'd1, 1'b1, 1'b1, T + 1, 1'b0, o);
    checks++;
    if (o.req_cyc !== T + 1 || o.err !== 0 || o.done_cyc !== e.done_cyc) begin
      failures++; $display("FAIL timeout_ack_wins: req=%0d err=%0d cyc=%0d expected %0d/0/%0d", o.req_cyc, o.err, o.done_cyc, T + 1, e.done_cyc);
    end
  endtask

  task automatic test_saturation();
    txn_t o, e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      e = model(1'b0, 1'b1, 1'b1, 0); bump(e);
      run_txn(1'b0, 2'(i), 1'b1, 1'b1, 0, 1'b0, o);
    end
    checks++;
    if (int'(hit_count) !== MAXC || exp_hit !== MAXC) begin
      failures++; $display("FAIL hit_saturate: hit=%0d expected %0d", hit_count, MAXC);
    end
    for (int i = 0; i < 5; i++) begin
      e = model(1'b1, 1'b0, 1'b0, 1); bump(e);
      run_txn(1'b1, 2'(i), 1'b0, 1'b0, 1, 1'b0, o);
    end
    checks++;
    if (int'(miss_count) !== MAXC || int'(hit_count) !== MAXC) begin
      failures++; $display("FAIL miss_saturate: miss=%0d hit=%0d expected %0d/%0d", miss_count, hit_count, MAXC, MAXC);
    end
  endtask

  task automatic test_reset_mid_fill();
    int seen_done;
    do_reset();
    run = 1'b1; RW = 1'b0; word_sel = 2'd1; hit = 1'b0; ram_ack = 1'b0;
    for (int c = 0; c < 10 && !ram_req; c++) begin
      step();
      run = 1'b0;
    end
    checks++;
    if (ram_req !== 1'b1) begin
      failures++; $display("FAIL midfill_reach: ram_req=%0b expected 1", ram_req);
    end
    gen_reset = 1'b1;
    step();
    gen_reset = 1'b0;
    checks++;
    if ({done, error, busy, ram_req, ram_we, SelecMemCPU, ReadEnableTag, cpu_word_we,
         write_enable_ram, enable_contadores, write_enable_cpu} !== '0 || hit_count !== 0 || miss_count !== 0) begin
      failures++; $display("FAIL midfill_reset: busy=%0b req=%0b miss=%0d hit=%0d expected all zero", busy, ram_req, miss_count, hit_count);
    end
    exp_hit = 0; exp_miss = 0;
    seen_done = 0;
    for (int c = 0; c < 4; c++) begin
      ram_ack = 1'b1;
      step();
      if (done || busy) seen_done++;
    end
    ram_ack = 1'b0;
    checks++;
    if (seen_done !== 0) begin
      failures++; $display("FAIL midfill_no_done: active cycles=%0d expected 0", seen_done);
    end
  endtask

  task automatic test_back_to_back();
    txn_t o1, o2, e1, e2;
    do_reset();
    e1 = model(1'b1, 1'b0, 1'b0, 1); bump(e1);
    run_txn(1'b1, 2'd2, 1'b0, 1'b0, 1, 1'b1, o1);
    e2 = model(1'b0, 1'b1, 1'b1, 0); bump(e2);
    run_txn(1'b0, 2'd3, 1'b1, 1'b1, 0, 1'b1, o2);
    checks++;
    if (o1.done_cyc !== e1.done_cyc || o2.done_cyc !== e2.done_cyc || o1.idle_bad !== 0 || o2.busy_bad !== 0) begin
      failures++; $display("FAIL back_to_back: cyc1=%0d cyc2=%0d idle_bad=%0d busy_bad=%0d expected %0d/%0d/0/0", o1.done_cyc, o2.done_cyc, o1.idle_bad, o2.busy_bad, e1.done_cyc, e2.done_cyc);
    end
    checks++;
    if (int'(hit_count) !== exp_hit || int'(miss_count) !== exp_miss) begin
      failures++; $display("FAIL back_to_back_counts: hit=%0d miss=%0d expected %0d/%0d", hit_count, miss_count, exp_hit, exp_miss);
    end
  endtask

  task automatic test_random();
    txn_t o, e;
    bit rw, h1, h2;
    bit [1:0] w;
    int k;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      rw = 1'($urandom_range(0, 1));
      w  = 2'($urandom_range(0, 3));
      h1 = 1'($urandom_range(0, 1));
      h2 = ($urandom_range(0, 3) != 0);
      k  = $urandom_range(0, T + 3);
      e = model(rw, h1, h2, k); bump(e);
      run_txn(rw, w, h1, h2, k, 1'b1, o);
      checks++;
      if (o.done_cyc !== e.done_cyc || o.err !== e.err || o.req_cyc !== e.req_cyc ||
          o.lookups !== e.lookups || o.ec !== e.ec || o.wer !== e.wer || o.cww !== e.cww) begin
        failures++;
        $display("FAIL rand_txn%0d rw=%0b h1=%0b h2=%0b k=%0d: cyc=%0d err=%0d req=%0d lk=%0d ec=%0d wer=%0d cww=%0d expected cyc=%0d err=%0d req=%0d lk=%0d ec=%0d wer=%0d cww=%0d",
                 i, rw, h1, h2, k, o.done_cyc, o.err, o.req_cyc, o.lookups, o.ec, o.wer, o.cww,
                 e.done_cyc, e.err, e.req_cyc, e.lookups, e.ec, e.wer, e.cww);
      end
      checks++;
      if (o.wer_bad !== 0 || o.cww_bad !== 0 || o.ramwe_bad !== 0 || o.busy_bad !== 0 || o.idle_bad !== 0 ||
          int'(hit_count) !== exp_hit || int'(miss_count) !== exp_miss) begin
        failures++;
        $display("FAIL rand_side%0d: wer_bad=%0d cww_bad=%0d ramwe_bad=%0d busy_bad=%0d idle_bad=%0d hit=%0d miss=%0d expected 0/0/0/0/0/%0d/%0d",
                 i, o.wer_bad, o.cww_bad, o.ramwe_bad, o.busy_bad, o.idle_bad, hit_count, miss_count, exp_hit, exp_miss);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_read_miss();
    test_write_hit();
    test_write_miss();
    test_timeout();
    test_saturation();
    test_reset_mid_fill();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
